// File: rtl/imem_stream_loader_if.sv
// imem_stream_loader_if: byte-stream valid/ready channel feeding the
// instruction-memory loader. The source drives data/valid/last and the
// loader returns ready.
interface imem_stream_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;

    modport master (output in_data, output in_valid, output in_last, input in_ready);
    modport slave  (input in_data, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/imem_stream_loader.sv
// imem_stream_loader: assembles a big-endian byte stream into 32-bit
// instruction words, writes them sequentially into instruction memory and
// holds the CPU stalled until the image is complete.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a CHECK state that
// compares a trailing XOR checksum byte against the image bytes.
module imem_stream_loader #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    imem_stream_loader_if.slave   stream,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_DONE  = 3'd2;
    localparam logic [2:0] S_ERROR = 3'd3;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHECK = 3'd4;
`endif

    logic [2:0]            state, state_nxt;
    logic                  ready_q, ready_nxt;
    logic [1:0]            byte_idx, idx_nxt;
    logic [23:0]           shift_q, shift_nxt;
    logic                  we_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [31:0]           wdata_nxt;
    logic                  hold_nxt, done_nxt, error_nxt;
    logic [ADDR_WIDTH:0]   words_nxt;
    logic                  fire;
    logic                  idle_like;
    logic [ADDR_WIDTH:0]   pending;
    logic [31:0]           word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            xor_q, xor_nxt;
`endif

    assign stream.in_ready = ready_q;
    assign fire      = stream.in_valid && ready_q;
    assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
    // Words written plus the one whose write strobe is in flight this cycle.
    assign pending   = words_loaded + CW'(imem_we);
    assign word      = {shift_q, stream.in_data};

    // Next-state and next-output decode.
    always_comb begin
        state_nxt = state;
        ready_nxt = 1'b0;
        idx_nxt   = byte_idx;
        shift_nxt = shift_q;
        we_nxt    = 1'b0;
        wdata_nxt = imem_wdata;
        hold_nxt  = cpu_hold;
        done_nxt  = done;
        error_nxt = error;
        addr_nxt  = imem_addr;
        words_nxt = words_loaded;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_nxt   = xor_q;
`endif

        if (imem_we) begin
            addr_nxt = imem_addr + ADDR_WIDTH'(1);
            if (words_loaded != CAPACITY) begin
                words_nxt = words_loaded + CW'(1);
            end
        end

        case (state)
            S_IDLE: begin
                hold_nxt = 1'b1;
            end
            S_LOAD: begin
                ready_nxt = 1'b1;
                if (fire) begin
                    if (pending == CAPACITY) begin
                        state_nxt = S_ERROR;
                        ready_nxt = 1'b0;
                    end else begin
                        shift_nxt = word[23:0];
                        idx_nxt   = byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_nxt   = xor_q ^ stream.in_data;
`endif
                        if (byte_idx == 2'd3) begin
                            we_nxt    = 1'b1;
                            wdata_nxt = word;
                            if (stream.in_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state_nxt = S_CHECK;
`else
                                state_nxt = S_DONE;
                                ready_nxt = 1'b0;
`endif
                            end
                        end else if (stream.in_last) begin
                            state_nxt = S_ERROR;
                            ready_nxt = 1'b0;
                        end
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                ready_nxt = 1'b1;
                if (fire) begin
                    ready_nxt = 1'b0;
                    state_nxt = (stream.in_data == xor_q) ? S_DONE : S_ERROR;
                end
            end
`endif
            S_DONE: begin
                done_nxt = 1'b1;
                hold_nxt = 1'b0;
            end
            S_ERROR: begin
                error_nxt = 1'b1;
                hold_nxt  = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
                hold_nxt  = 1'b1;
            end
        endcase

        // A new load can only be launched from a resting state.
        if (start && idle_like) begin
            state_nxt = S_LOAD;
            ready_nxt = 1'b1;
            idx_nxt   = 2'd0;
            hold_nxt  = 1'b1;
            done_nxt  = 1'b0;
            error_nxt = 1'b0;
            addr_nxt  = '0;
            words_nxt = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_nxt   = 8'd0;
`endif
        end
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            ready_q      <= 1'b0;
            byte_idx     <= 2'd0;
            shift_q      <= 24'd0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 32'd0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q        <= 8'd0;
`endif
        end else begin
            state        <= state_nxt;
            ready_q      <= ready_nxt;
            byte_idx     <= idx_nxt;
            shift_q      <= shift_nxt;
            imem_we      <= we_nxt;
            imem_addr    <= addr_nxt;
            imem_wdata   <= wdata_nxt;
            cpu_hold     <= hold_nxt;
            done         <= done_nxt;
            error        <= error_nxt;
            words_loaded <= words_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q        <= xor_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_imem_stream_loader.sv
// tb_imem_stream_loader: directed bench for imem_stream_loader with an
// image-level model of expected writes and final status.
module tb_imem_stream_loader;
    localparam int unsigned AW  = 2;
    localparam int unsigned CAP = 1 << AW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold, done, error;
    logic [AW:0]   words_loaded;

    imem_stream_loader_if sif ();

    imem_stream_loader #(.ADDR_WIDTH(AW)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .stream       (sif),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clock = ~clock;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] exp_data_q[$];
    int          exp_addr_q[$];
    bit          exp_done, exp_error;
    int          exp_words, exp_acc;
    logic [7:0]  exp_xor;
    int          pop_addr;
    logic [31:0] pop_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    // Every write strobe must match the next word the model predicted.
    always @(negedge clock) begin
        if (!reset && imem_we) begin
            if (exp_data_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", imem_addr, imem_wdata);
            end else begin
                pop_addr = exp_addr_q.pop_front();
                pop_data = exp_data_q.pop_front();
                check("write_addr", 32'(imem_addr), 32'(pop_addr));
                check("write_data", imem_wdata, pop_data);
            end
        end
    end

    // Image-level model: which words land where and how the load ends.
    task automatic model_image(input logic [7:0] b[$], input bit has_last);
        exp_done  = 0;
        exp_error = 0;
        exp_words = 0;
        exp_acc   = b.size();
        exp_xor   = 8'd0;
        for (int k = 0; k < b.size(); k++) begin
            if (k / 4 >= int'(CAP)) begin
                exp_error = 1;
                exp_acc   = k + 1;
                break;
            end
            exp_xor = exp_xor ^ b[k];
            if (k % 4 == 3) begin
                exp_addr_q.push_back(k / 4);
                exp_data_q.push_back({b[k-3], b[k-2], b[k-1], b[k]});
                exp_words++;
            end
            if (has_last && k == b.size() - 1) begin
                if (k % 4 == 3) exp_done = 1;
                else            exp_error = 1;
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_hold"},  32'(cpu_hold), 32'd1);
        check({tag, "_ready"}, 32'(sif.in_ready), 32'd0);
        check({tag, "_we"},    32'(imem_we), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_addr"},  32'(imem_addr), 32'd0);
        check({tag, "_wdata"}, imem_wdata, 32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Offer one byte after optional idle gap cycles; give up after 8 stalled cycles.
    task automatic send_byte(input logic [7:0] d, input bit l, input int gap, output bit ok);
        bit r;
        ok = 0;
        for (int g = 0; g < gap; g++) begin
            sif.in_valid = 1'b0;
            @(posedge clock); #1;
        end
        sif.in_valid = 1'b1;
        sif.in_data  = d;
        sif.in_last  = l;
        for (int w = 0; w < 8 && !ok; w++) begin
            @(negedge clock);
            r = sif.in_ready;
            @(posedge clock); #1;
            if (r) ok = 1;
        end
        sif.in_valid = 1'b0;
        sif.in_last  = 1'b0;
    endtask

    task automatic run_load(input logic [7:0] b[$], input bit has_last, input bit gapped,
                            input logic [7:0] ck_delta, input bit tail_check);
        bit ok;
        int acc;
        model_image(b, has_last);
        do_start();
        acc = 0;
        for (int i = 0; i < b.size(); i++) begin
            send_byte(b[i], has_last && (i == b.size() - 1), (gapped && i > 0) ? 1 : 0, ok);
            if (!ok) break;
            acc++;
`ifndef IMEM_LOADER_CHECKSUM_EN
            if (tail_check && i == b.size() - 1) begin
                @(negedge clock);
                check("tail_hold_at_write", 32'(cpu_hold), 32'd1);
                check("tail_we_at_write",   32'(imem_we), 32'd1);
                check("tail_ready_low",     32'(sif.in_ready), 32'd0);
                @(negedge clock);
                check("tail_hold_released", 32'(cpu_hold), 32'd0);
                check("tail_done_rise",     32'(done), 32'd1);
            end
`endif
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (exp_done) begin
            send_byte(exp_xor ^ ck_delta, 1'b0, 0, ok);
            check("checksum_accepted", 32'(ok), 32'd1);
            exp_done  = (ck_delta == 8'd0);
            exp_error = !exp_done;
        end
`endif
        check("bytes_accepted", 32'(acc), 32'(exp_acc));
        repeat (4) @(posedge clock);
        @(negedge clock);
        check("final_done",    32'(done), 32'(exp_done));
        check("final_error",   32'(error), 32'(exp_error));
        check("final_hold",    32'(cpu_hold), 32'(!exp_done));
        check("final_words",   32'(words_loaded), 32'(exp_words));
        check("writes_missed", 32'(exp_data_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] img[$];
        logic [7:0] part[$];
        bit ok;

        sif.in_valid = 1'b0;
        sif.in_data  = 8'd0;
        sif.in_last  = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_reset_state("reset");

        // Normal load, with literal pins on the model's predicted words.
        img = '{8'h20, 8'h03, 8'h00, 8'h05, 8'h08, 8'h00, 8'h00, 8'h00};
        model_image(img, 1'b1);
        check("model_word0", exp_data_q[0], 32'h2003_0005);
        check("model_word1", exp_data_q[1], 32'h0800_0000);
        check("model_words", 32'(exp_words), 32'd2);
        exp_data_q.delete();
        exp_addr_q.delete();
        run_load(img, 1'b1, 1'b0, 8'd0, 1'b1);
        check("normal_words_lit", 32'(words_loaded), 32'd2);
        check("normal_done_lit",  32'(done), 32'd1);

        // Same image with in_valid dropped on alternate cycles.
        run_load(img, 1'b1, 1'b1, 8'd0, 1'b0);
        check("gapped_words_lit", 32'(words_loaded), 32'd2);

        // Short final word.
        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        run_load(img, 1'b1, 1'b0, 8'd0, 1'b0);
        check("short_error_lit", 32'(error), 32'd1);
        check("short_done_lit",  32'(done), 32'd0);
        check("short_words_lit", 32'(words_loaded), 32'd1);

        // Overflow: 20 bytes into a 4-word memory.
        img.delete();
        for (int i = 0; i < 20; i++) img.push_back(8'(i + 1));
        run_load(img, 1'b1, 1'b0, 8'd0, 1'b0);
        check("ovf_acc_lit",   32'(exp_acc), 32'd17);
        check("ovf_error_lit", 32'(error), 32'd1);
        check("ovf_words_lit", 32'(words_loaded), 32'd4);

        // Reset after 5 bytes, then a fresh single-word image.
        part = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        model_image(part, 1'b0);
        do_start();
        for (int i = 0; i < 5; i++) begin
            send_byte(part[i], 1'b0, 0, ok);
            check("midload_accept", 32'(ok), 32'd1);
        end
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_reset_state("midreset");
        check("midload_write_seen", 32'(exp_data_q.size()), 32'd0);
        img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_load(img, 1'b1, 1'b0, 8'd0, 1'b0);
        check("restart_words_lit", 32'(words_loaded), 32'd1);
        check("restart_done_lit",  32'(done), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        img = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load(img, 1'b1, 1'b0, 8'd0, 1'b0);
        check("ck_good_done_lit", 32'(done), 32'd1);
        run_load(img, 1'b1, 1'b0, 8'd1, 1'b0);
        check("ck_bad_error_lit", 32'(error), 32'd1);
        check("ck_bad_hold_lit",  32'(cpu_hold), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_stream_loader.md
# imem_stream_loader

Hardware program loader for the mips16_sc instruction memory, replacing simulation-only `$readmemb` preloading. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes each word sequentially into the instruction register file. It holds the CPU in stall until the image is loaded and verified.

## Interface
- `ADDR_WIDTH`, 8: instruction memory word-address width. Capacity is 2^ADDR_WIDTH words.
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: one-cycle pulse that begins a new load.
- `in_data`  in  8: stream byte, most significant byte of each word first.
- `in_valid`  in  1: `in_data` is valid.
- `in_last`  in  1: qualifies the final image byte. Valid only with `in_valid`.
- `in_ready`  out  1: loader accepts a byte on this cycle.
- `imem_we`  out  1: instruction memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_WIDTH: word address of the write.
- `imem_wdata`  out  32: assembled instruction word.
- `cpu_hold`  out  1: stall request to the CPU. Drives the instruction-stall path.
- `done`  out  1: sticky; the load completed without error.
- `error`  out  1: sticky; the load was aborted.
- `words_loaded`  out  ADDR_WIDTH+1: number of words written in the current or last load.

## Operation
- A transfer occurs on any cycle with `in_valid && in_ready`.
- FSM states: IDLE, LOAD, CHECK (present only with the macro), DONE, ERROR.
- **IDLE/DONE/ERROR** + `start`:
  - go to LOAD;
  - clear `done`, `error`, `words_loaded`, the byte index and the word address;
  - set `cpu_hold`=1.
- `start` while in LOAD or CHECK is ignored.
- **LOAD**:
  - `in_ready`=1.
  - Each accepted byte shifts into the word shift register.
  - The byte index counts 0..3 and wraps to 0.
  - On accepting byte index 3, the word is complete and a write is scheduled.
- **End of image**: the byte with `in_last` and byte index 3 finishes the image.
  - Without the macro, go to DONE.
  - With the macro, go to CHECK.
- **Short word**: `in_last` with byte index ≠3 → ERROR. The partial word is discarded and not written.
- **Overflow**: a byte accepted when `words_loaded` == 2^ADDR_WIDTH → ERROR. Nothing is written.
- **DONE**: `done`=1, `cpu_hold`=0, `in_ready`=0.
- **ERROR**: `error`=1, `cpu_hold` stays 1, `in_ready`=0.
- `words_loaded` saturates at 2^ADDR_WIDTH.

## Timing
- Reset values:
  - state = IDLE;
  - `cpu_hold`=1;
  - `in_ready`=0, `imem_we`=0, `done`=0, `error`=0;
  - `imem_addr`=0, `imem_wdata`=0, `words_loaded`=0.
- `in_ready` is a registered output: high from the cycle after `start` is sampled until the cycle after the terminating byte.
- Throughput: 1 byte/cycle sustained with no bubbles. `in_valid` may drop at any time with no penalty.
- Write latency: `imem_we` pulses on the cycle after byte index 3 is accepted.
  - `imem_addr` and `imem_wdata` are valid in that same cycle.
  - `words_loaded` and the word address increment at the end of that cycle.
- The final word's write and the DONE entry coincide. `done` rises and `cpu_hold` falls together, one cycle after the write (two cycles after the last byte without the macro).
- Reset mid-load:
  - abort immediately and enter the reset state (`cpu_hold`=1);
  - words already written remain in memory;
  - `done` stays 0.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - After the `in_last` word, LOAD→CHECK, with `in_ready` held 1.
  - The next accepted byte is the checksum: the XOR of all image bytes.
  - On a match, go to DONE one cycle later. On a mismatch, go to ERROR.
  - `in_last` on the checksum byte is don't-care.
  - A running 8-bit XOR register is cleared on `start`.
- Undefined:
  - No CHECK state and no XOR register.
  - The `in_last` word leads directly to DONE.

## Test plan
- **Normal load**: reset, `start`, stream 8 bytes 0x20,0x03,0x00,0x05, 0x08,0x00,0x00,0x00 with `in_last` on byte 8. Required response:
  - writes addr0=0x20030005 and addr1=0x08000000;
  - `words_loaded`=2, `done`=1;
  - `cpu_hold` 1→0 two cycles after the last byte.
- **Gapped stream**: the same image with `in_valid` low on alternate cycles. Required response: identical writes and data; the `imem_we` pulses are spaced by the gaps.
- **Short word**: 6 bytes with `in_last` on byte 6. Required response:
  - exactly 1 write;
  - `error`=1, `cpu_hold`=1, `done`=0, `words_loaded`=1.
- **Overflow** with ADDR_WIDTH=2: 20 bytes. Required response:
  - 4 writes to addresses 0..3;
  - `error`=1 on the 17th byte;
  - `words_loaded`=4.
- **Reset mid-load then restart**: reset after 5 bytes, then a fresh `start` and a 4-byte image 0xDEADBEEF. Required response: addr0=0xDEADBEEF, `done`=1, `words_loaded`=1.
- **Checksum** (`IMEM_LOADER_CHECKSUM_EN` defined): image 0x01,0x02,0x03,0x04. Required response:
  - checksum byte 0x04 → `done`=1;
  - checksum byte 0x05 → `error`=1, `cpu_hold`=1.
